// File: rtl/div128by64_m.sv
// Sequential unsigned divider: 2W-bit dividend by W-bit divisor.
// Radix-2 restoring, one quotient bit per clock, start/ready/done handshake.
module div128by64_m #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           done,
  output logic           dbz,
  output logic           ovf
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] ITER  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  rem;
  logic [W-1:0]  qsh;
  logic [W-1:0]  dv;
  logic [CW-1:0] cnt;

  logic [W:0]    t;
  logic [W:0]    diff;
  logic          ge;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  qsh_nx;

  // t can reach 2^W, so compare and subtract need the extra bit
  always_comb begin
    t      = {rem, qsh[W-1]};
    diff   = t - {1'b0, dv};
    ge     = (t >= {1'b0, dv});
    rem_nx = ge ? diff[W-1:0] : t[W-1:0];
    qsh_nx = {qsh[W-2:0], ge};
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      qsh   <= '0;
      dv    <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem   <= n[2*W-1:W];
            qsh   <= n[W-1:0];
            dv    <= d;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (dv == '0) begin
            q     <= '1;
            r     <= '0;
            dbz   <= 1'b1;
            ovf   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (rem >= dv) begin
            q     <= '1;
            r     <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= CW'(W - 1);
            dbz   <= 1'b0;
            ovf   <= 1'b0;
            state <= ITER;
          end
        end
        ITER: begin
          rem <= rem_nx;
          qsh <= qsh_nx;
          if (cnt == '0) begin
            // results land on the final step so they are valid with done
            q     <= qsh_nx;
            r     <= rem_nx;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div128by64_m.sv
// Self-checking bench for div128by64_m.
// Random and directed divisions checked against a wide-arithmetic model.
module tb_div128by64_m;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] n = '0;
  logic [W-1:0]   d = '0;
  logic           ready;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           done;
  logic           dbz;
  logic           ovf;

  int pass = 0;
  int total = 0;

  div128by64_m #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ready(ready),
    .n(n),
    .d(d),
    .q(q),
    .r(r),
    .done(done),
    .dbz(dbz),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic model(
    input  logic [2*W-1:0] mn,
    input  logic [W-1:0]   md,
    output logic [W-1:0]   eq,
    output logic [W-1:0]   er,
    output logic           edbz,
    output logic           eovf
  );
    logic [2*W-1:0] wd, qq, rr;
    wd = {{W{1'b0}}, md};
    if (md == '0) begin
      eq = '1; er = '0; edbz = 1'b1; eovf = 1'b0;
    end else if (mn[2*W-1:W] >= md) begin
      eq = '1; er = '0; edbz = 1'b0; eovf = 1'b1;
    end else begin
      qq = mn / wd;
      rr = mn % wd;
      eq = qq[W-1:0]; er = rr[W-1:0];
      edbz = 1'b0; eovf = 1'b0;
    end
  endtask

  // Drive one operation from IDLE and report what the DUT showed at done.
  task automatic run_op(
    input  logic [2*W-1:0] ni,
    input  logic [W-1:0]   di,
    output logic [W-1:0]   oq,
    output logic [W-1:0]   orr,
    output logic           odbz,
    output logic           oovf,
    output int             lat,
    output logic           adone,
    output logic           ardy
  );
    n = ni; d = di; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = ~ni; d = ~di;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    oq = q; orr = r; odbz = dbz; oovf = ovf;
    @(posedge clk); #1;
    adone = done; ardy = ready;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({ready, done, dbz, ovf, q, r} !== {4'b1000, {2*W{1'b0}}}) begin
      $display("FAIL reset: rdy=%b done=%b dbz=%b ovf=%b q=%h r=%h want 1 0 0 0 0 0",
               ready, done, dbz, ovf, q, r);
    end else pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] oq, orr;
    logic odbz, oovf, adone, ardy;
    int lat;
    run_op(128'd100, 64'd7, oq, orr, odbz, oovf, lat, adone, ardy);
    total++;
    if (lat !== W + 2) $display("FAIL basic_lat: got %0d want %0d", lat, W + 2);
    else pass++;
    total++;
    if ({oq, orr, odbz, oovf} !== {64'd14, 64'd2, 2'b00})
      $display("FAIL basic_res: q=%0d r=%0d dbz=%b ovf=%b want 14 2 0 0", oq, orr, odbz, oovf);
    else pass++;
    total++;
    if ({adone, ardy} !== 2'b01)
      $display("FAIL basic_after: done=%b ready=%b want 0 1", adone, ardy);
    else pass++;
  endtask

  task automatic test_product();
    logic [W-1:0] oq, orr;
    logic odbz, oovf, adone, ardy;
    int lat;
    run_op({64'hFFFF_FFFF_FFFF_FFFE, 64'h1}, '1, oq, orr, odbz, oovf, lat, adone, ardy);
    total++;
    if ({oq, orr, odbz, oovf} !== {{W{1'b1}}, {W{1'b0}}, 2'b00})
      $display("FAIL product: q=%h r=%h dbz=%b ovf=%b want all-ones 0 0 0", oq, orr, odbz, oovf);
    else pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] oq, orr, eq, er, dd, hi;
    logic [2*W-1:0] nn, recon;
    logic odbz, oovf, adone, ardy, edbz, eovf;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      dd = {$urandom, $urandom} >> ($urandom % W);
      if (dd == '0) dd = 64'd1;
      hi = {$urandom, $urandom} % dd;
      nn = {hi, $urandom, $urandom};
      run_op(nn, dd, oq, orr, odbz, oovf, lat, adone, ardy);
      model(nn, dd, eq, er, edbz, eovf);
      recon = {{W{1'b0}}, oq} * {{W{1'b0}}, dd} + {{W{1'b0}}, orr};
      total++;
      if ({oq, orr, odbz, oovf} !== {eq, er, edbz, eovf} || recon !== nn || !(orr < dd)) begin
        if (bad < 5)
          $display("FAIL random: n=%h d=%h q=%h r=%h want q=%h r=%h", nn, dd, oq, orr, eq, er);
        bad++;
      end else pass++;
      if (lat != W + 2) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL random_summary: bad=%0d want 0", bad);
    else pass++;
  endtask

  task automatic test_dbz();
    logic [W-1:0] oq, orr;
    logic odbz, oovf, adone, ardy;
    int lat;
    run_op({$urandom, $urandom, $urandom, $urandom}, '0, oq, orr, odbz, oovf, lat, adone, ardy);
    total++;
    if (lat !== 2) $display("FAIL dbz_lat: got %0d want 2", lat);
    else pass++;
    total++;
    if ({oq, orr, odbz, oovf} !== {{W{1'b1}}, {W{1'b0}}, 2'b10})
      $display("FAIL dbz_res: q=%h r=%h dbz=%b ovf=%b want all-ones 0 1 0", oq, orr, odbz, oovf);
    else pass++;
    total++;
    if ({adone, ardy} !== 2'b01)
      $display("FAIL dbz_after: done=%b ready=%b want 0 1", adone, ardy);
    else pass++;
  endtask

  task automatic test_ovf();
    logic [W-1:0] oq, orr, eq, er;
    logic [2*W-1:0] nn;
    logic odbz, oovf, adone, ardy, edbz, eovf;
    int lat;
    nn = {64'd5, $urandom, $urandom};
    run_op(nn, 64'd5, oq, orr, odbz, oovf, lat, adone, ardy);
    total++;
    if (lat !== 2 || {oq, orr, odbz, oovf} !== {{W{1'b1}}, {W{1'b0}}, 2'b01})
      $display("FAIL ovf: lat=%0d q=%h r=%h dbz=%b ovf=%b want 2 all-ones 0 0 1",
               lat, oq, orr, odbz, oovf);
    else pass++;
    nn = {64'd4, $urandom, $urandom};
    run_op(nn, 64'd5, oq, orr, odbz, oovf, lat, adone, ardy);
    model(nn, 64'd5, eq, er, edbz, eovf);
    total++;
    if (lat !== W + 2 || {oq, orr, odbz, oovf} !== {eq, er, edbz, eovf})
      $display("FAIL ovf_edge: lat=%0d q=%h r=%h want %0d q=%h r=%h", lat, oq, orr, W + 2, eq, er);
    else pass++;
  endtask

  task automatic test_ignore_and_abort();
    logic [W-1:0] eq, er;
    logic edbz, eovf;
    logic [2*W-1:0] na;
    int e, dcount;
    na = {64'h1234, 64'hDEAD_BEEF_0000_0001};
    model(na, 64'h9_8765, eq, er, edbz, eovf);
    n = na; d = 64'h9_8765; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 1;
    while (!done && e < 200) begin
      if (e == 9) begin
        start = 1'b1; n = {64'd3, 64'd77}; d = 64'd11;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    total++;
    if (e !== W + 2 || {q, r, dbz, ovf} !== {eq, er, edbz, eovf})
      $display("FAIL ignore: lat=%0d q=%h r=%h want %0d q=%h r=%h", e, q, r, W + 2, eq, er);
    else pass++;
    @(posedge clk); #1;
    n = {64'd2, 64'd99}; d = 64'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready, done, q, r} !== {2'b10, {2*W{1'b0}}})
      $display("FAIL abort: ready=%b done=%b q=%h r=%h want 1 0 0 0", ready, done, q, r);
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    total++;
    if (dcount !== 0) $display("FAIL abort_nodone: pulses=%0d want 0", dcount);
    else pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq, er;
    logic edbz, eovf;
    logic [2*W-1:0] nn;
    int edges[$];
    int c;
    nn = {64'h0FED_CBA9, 64'h7654_3210_AAAA_5555};
    model(nn, 64'h1_0000_0003, eq, er, edbz, eovf);
    n = nn; d = 64'h1_0000_0003; start = 1'b1;
    c = 0;
    while (edges.size() < 3 && c < 3 * (W + 3) + 20) begin
      @(posedge clk); #1;
      c++;
      if (done) begin
        edges.push_back(c);
        total++;
        if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf})
          $display("FAIL b2b_res%0d: q=%h r=%h want q=%h r=%h", edges.size(), q, r, eq, er);
        else pass++;
        if (edges.size() == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (edges.size() !== 3) $display("FAIL b2b_count: got %0d want 3", edges.size());
    else pass++;
    if (edges.size() == 3) begin
      total++;
      if (edges[1] - edges[0] !== W + 3 || edges[2] - edges[1] !== W + 3)
        $display("FAIL b2b_spacing: got %0d,%0d want %0d", edges[1] - edges[0],
                 edges[2] - edges[1], W + 3);
      else pass++;
    end
    c = 0;
    while (!ready && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_product();
    test_dbz();
    test_ovf();
    test_random();
    test_ignore_and_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/div128by64_m.md
Name: div128by64_m

Overview:
- Sequential unsigned divider: 2*W-bit dividend by W-bit divisor, producing a W-bit quotient and a W-bit remainder.
- Inverse companion of the 64x64 Karatsuba multiplier. Typical use: recovering an operand or scaling a product back down.
- Radix-2 restoring algorithm, one quotient bit per clock. No DSP blocks.
- Same start/ready handshake style as the multiplier, plus a one-cycle done strobe and error flags.

Parameters:
- W, 64, operand width. Dividend is 2*W bits; divisor, quotient and remainder are W bits. Legal values: 8..128.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- ready  output  1  high in IDLE; block can accept start
- n  input  2*W  dividend; sampled on accepted start
- d  input  W  divisor; sampled on accepted start
- q  output  W  quotient; registered
- r  output  W  remainder; registered
- done  output  1  one-cycle strobe: q, r and flags are valid
- dbz  output  1  divide-by-zero flag, valid with done
- ovf  output  1  quotient-overflow flag (n[2W-1:W] >= d, d != 0), valid with done

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; q, r, dbz, ovf all '0; done=0; internal registers cleared.
  - Reset mid-operation aborts the division. No done is issued.
  - First accepted start is possible on the first edge after rst_n rises.
- States: IDLE, CHECK, ITER, DONE. ready = (state==IDLE).
- IDLE:
  - On start=1, latch: rem <= n[2W-1:W], qsh <= n[W-1:0], dv <= d.
  - Go to CHECK. start=0 keeps IDLE.
- CHECK:
  - If dv==0: q<='1, r<='0, dbz<=1, ovf<=0. Go to DONE.
  - Else if rem>=dv: q<='1, r<='0, ovf<=1, dbz<=0. Go to DONE.
  - Else: cnt<=W-1, clear both flags. Go to ITER.
- ITER (exactly W cycles):
  - Form the (W+1)-bit value t = {rem, qsh[W-1]}.
  - If t >= dv: rem <= t - dv (truncated to W bits), bit=1. Else rem <= t[W-1:0], bit=0.
  - qsh <= {qsh[W-2:0], bit}.
  - Compare and subtract must use W+1 bits, because rem < dv holds but t may exceed 2^W.
  - If cnt==0: go to DONE. Else cnt<=cnt-1.
  - cnt width is clog2(W).
- DONE:
  - In the normal path, q and r are loaded from qsh and rem. Error values were already loaded in CHECK.
  - done=1 for exactly this cycle. Go to IDLE.
- Latency, counted from the edge that samples start:
  - Normal path: done is high in the cycle after edge W+2. For W=64: done after edge 66, ready again after edge 67.
  - Error path: done is high after edge 2, ready again after edge 3.
- Handshake and output rules:
  - start while ready=0 is ignored. No queueing.
  - start held high continuously gives back-to-back operations, restarting on the first IDLE cycle.
  - n and d may change freely after the accepting edge.
  - q, r, dbz and ovf hold their values until CHECK or DONE of the next operation updates them.
  - done is never asserted in IDLE.
- Correctness (normal path): n == q*d + r and r < d. Valid only for unsigned operands.

Test Plan:
- W=64, n=0x0000...0000_0000_0000_0000_0064 (100), d=7 -> after 66 edges done=1 for one cycle, q=14, r=2, dbz=0, ovf=0; ready=1 on the following cycle.
- n=0xFFFFFFFFFFFFFFFE_0000000000000001 (a product from the 64x64 multiplier), d=0xFFFFFFFFFFFFFFFF -> q=0xFFFFFFFFFFFFFFFF, r=0. Also run 1000 random n with n[127:64] < d against the reference model n==q*d+r, r<d.
- d=0, n=any -> done after 2 edges, dbz=1, ovf=0, q=all ones, r=0.
- n[127:64]=5, d=5 -> done after 2 edges, ovf=1, dbz=0, q=all ones, r=0. Repeat with n[127:64]=4, d=5 -> normal path, correct q and r.
- Assert start again at edge 10 of an operation with different operands -> ignored; result matches the first operation. Then pull rst_n low at edge 30 of a new operation -> immediately ready=1, q=r=0, done=0; no done pulse follows.
- Hold start=1 with fixed operands for three operations -> three done pulses spaced W+3 cycles apart, identical results.
